move_arbiter: RTL and testbench

- Downstream consumer of the Transmitter stage in the move generator.
- Per board square, accepts the Transmitter's 16 direction score lanes (U..RRD) with the square's position.
- Serially reduces the lanes across all squares of a search pass to the single best move: source square, direction and target square.
- Drives arb_posout back to the Transmitter and reports pass completion to the engine controller.

---
 rtl/move_arbiter.sv | 154 +++++++++++++++
 tb/tb_move_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/move_arbiter.sv
// rtl/move_arbiter.sv - serial best-move arbiter over 16 direction score lanes per square
// Scans one lane per cycle, masks off-board steps, keeps the first-seen strict maximum.
module move_arbiter #(
  parameter int SCORE_W = 5,
  parameter int POS_W   = 6,
  parameter int NLANES  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      sq_valid,
  output logic                      sq_ready,
  input  logic                      sq_last,
  input  logic [POS_W-1:0]          pos_in,
  input  logic [NLANES*SCORE_W-1:0] cand_scores,
  output logic [SCORE_W-1:0]        best_score,
  output logic [POS_W-1:0]          best_from,
  output logic [3:0]                best_dir,
  output logic [POS_W-1:0]          arb_posout,
  output logic                      busy,
  output logic                      done,
  output logic                      no_move
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SCAN, S_DONE} state_t;

  // File step of each lane (signed, 7-bit so it composes directly with positions).
  function automatic logic signed [6:0] lane_df(input logic [3:0] k);
    case (k)
      4'd2, 4'd4, 4'd6, 4'd8, 4'd12:   lane_df = -7'sd1;
      4'd3, 4'd5, 4'd7, 4'd9, 4'd13:   lane_df =  7'sd1;
      4'd10, 4'd14:                    lane_df = -7'sd2;
      4'd11, 4'd15:                    lane_df =  7'sd2;
      default:                         lane_df =  7'sd0;
    endcase
  endfunction

  function automatic logic signed [6:0] lane_dr(input logic [3:0] k);
    case (k)
      4'd0, 4'd4, 4'd5, 4'd10, 4'd11:  lane_dr =  7'sd1;
      4'd1, 4'd6, 4'd7, 4'd14, 4'd15:  lane_dr = -7'sd1;
      4'd8, 4'd9:                      lane_dr =  7'sd2;
      4'd12, 4'd13:                    lane_dr = -7'sd2;
      default:                         lane_dr =  7'sd0;
    endcase
  endfunction

  state_t                    r_state;
  logic [3:0]                r_lane;
  logic [NLANES*SCORE_W-1:0] r_cand;
  logic [POS_W-1:0]          r_pos;
  logic                      r_last;
  logic [SCORE_W-1:0]        r_best_score;
  logic [POS_W-1:0]          r_best_from;
  logic [3:0]                r_best_dir;
  logic                      r_sq_ready;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_no_move;

  logic signed [6:0]         w_tf;
  logic signed [6:0]         w_tr;
  logic                      w_on_board;
  logic [SCORE_W-1:0]        w_masked;
  logic                      w_take;
  logic signed [6:0]         w_off;
  logic signed [6:0]         w_sum;

  // Mask check is done on separate file/rank coordinates, so wraps are never legal.
  assign w_tf       = $signed({4'b0000, r_pos[2:0]}) + lane_df(r_lane);
  assign w_tr       = $signed({4'b0000, r_pos[5:3]}) + lane_dr(r_lane);
  assign w_on_board = (w_tf >= 7'sd0) && (w_tf <= 7'sd7) && (w_tr >= 7'sd0) && (w_tr <= 7'sd7);
  assign w_masked   = w_on_board ? r_cand[SCORE_W-1:0] : '0;
  assign w_take     = (w_masked > r_best_score);

  assign w_off      = (lane_dr(r_best_dir) <<< 3) + lane_df(r_best_dir);
  assign w_sum      = $signed({1'b0, r_best_from}) + w_off;
  assign arb_posout = (r_best_score == '0) ? '0 : w_sum[POS_W-1:0];

  assign best_score = r_best_score;
  assign best_from  = r_best_from;
  assign best_dir   = r_best_dir;
  assign sq_ready   = r_sq_ready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign no_move    = r_no_move;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_lane       <= '0;
      r_cand       <= '0;
      r_pos        <= '0;
      r_last       <= 1'b0;
      r_best_score <= '0;
      r_best_from  <= '0;
      r_best_dir   <= '0;
      r_sq_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_no_move    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_best_score <= '0;
            r_best_from  <= '0;
            r_best_dir   <= '0;
            r_no_move    <= 1'b0;
            r_sq_ready   <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (sq_valid) begin
            r_cand     <= cand_scores;
            r_pos      <= pos_in;
            r_last     <= sq_last;
            r_lane     <= '0;
            r_sq_ready <= 1'b0;
            r_state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_take) begin
            r_best_score <= w_masked;
            r_best_from  <= r_pos;
            r_best_dir   <= r_lane;
          end
          r_cand <= r_cand >> SCORE_W;
          r_lane <= r_lane + 4'd1;
          if (r_lane == 4'(NLANES - 1)) begin
            if (r_last) begin
              r_done    <= 1'b1;
              r_no_move <= !w_take && (r_best_score == '0);
              r_state   <= S_DONE;
            end else begin
              r_sq_ready <= 1'b1;
              r_state    <= S_WAIT;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_arbiter.sv
// tb/tb_move_arbiter.sv - self-checking bench for move_arbiter
// Directed scenarios plus randomized passes against an offset-table move model.
module tb_move_arbiter;
  localparam int SW = 5;
  localparam int PW = 6;
  localparam int NL = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             sq_valid = 1'b0;
  logic             sq_ready;
  logic             sq_last = 1'b0;
  logic [PW-1:0]    pos_in = '0;
  logic [NL*SW-1:0] cand_scores = '0;
  logic [SW-1:0]    best_score;
  logic [PW-1:0]    best_from;
  logic [3:0]       best_dir;
  logic [PW-1:0]    arb_posout;
  logic             busy;
  logic             done;
  logic             no_move;

  move_arbiter #(.SCORE_W(SW), .POS_W(PW), .NLANES(NL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sq_valid(sq_valid), .sq_ready(sq_ready),
    .sq_last(sq_last), .pos_in(pos_in), .cand_scores(cand_scores), .best_score(best_score),
    .best_from(best_from), .best_dir(best_dir), .arb_posout(arb_posout), .busy(busy),
    .done(done), .no_move(no_move)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int nsq;
  int sq_pos[8];
  int sq_sc[8][16];
  int off_tab[16] = '{8, -8, -1, 1, 7, 9, -9, -7, 15, 17, 6, 10, -17, -15, -10, -6};
  int exp_score, exp_from, exp_dir, exp_tgt;
  int lat_bad, timeouts, extra_done;
  int obs_score, obs_from, obs_dir, obs_tgt, obs_nomove, obs_done, obs_done_next, obs_busy_next;

  function automatic int abs_i(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int legal(input int p, input int k);
    int t;
    t = p + off_tab[k];
    if (t < 0 || t > 63) return 0;
    return (abs_i(t % 8 - p % 8) <= 2 && abs_i(t / 8 - p / 8) <= 2) ? 1 : 0;
  endfunction

  task automatic model_pass();
    exp_score = 0; exp_from = 0; exp_dir = 0;
    for (int i = 0; i < nsq; i++)
      for (int k = 0; k < NL; k++)
        if (legal(sq_pos[i], k) != 0 && sq_sc[i][k] > exp_score) begin
          exp_score = sq_sc[i][k]; exp_from = sq_pos[i]; exp_dir = k;
        end
    exp_tgt = (exp_score != 0) ? exp_from + off_tab[exp_dir] : 0;
  endtask

  task automatic clear_squares();
    for (int i = 0; i < 8; i++) begin
      sq_pos[i] = 0;
      for (int k = 0; k < NL; k++) sq_sc[i][k] = 0;
    end
  endtask

  task automatic do_pass(input int poke_start);
    int n;
    int cyc;
    lat_bad = 0; timeouts = 0; extra_done = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < nsq; i++) begin
      pos_in = sq_pos[i][PW-1:0];
      for (int k = 0; k < NL; k++) cand_scores[k*SW +: SW] = sq_sc[i][k][SW-1:0];
      sq_last = (i == nsq - 1);
      sq_valid = 1'b1;
      n = 0;
      while (!sq_ready && n < 50) begin @(posedge clk); #1 n++; end
      if (n >= 50) timeouts++;
      @(posedge clk); #1;
      sq_valid = 1'b0;
      cand_scores = {$urandom, $urandom, $urandom};
      pos_in = PW'($urandom);
      sq_last = $urandom_range(0, 1) == 1;
      cyc = 1;
      while (!(done || sq_ready) && cyc < 60) begin
        start = (poke_start != 0 && i == 0 && cyc == 3);
        @(posedge clk); #1 cyc++;
      end
      start = 1'b0;
      if (cyc != 17) lat_bad++;
      if (cyc >= 60) timeouts++;
    end
    obs_done = done; obs_score = best_score; obs_from = best_from; obs_dir = best_dir;
    obs_tgt = arb_posout; obs_nomove = no_move;
    @(posedge clk); #1;
    obs_done_next = done; obs_busy_next = busy;
    repeat (4) begin @(posedge clk); #1 if (done) extra_done++; end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({sq_ready, busy, done, no_move, best_score, best_from, best_dir, arb_posout} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0",
        {sq_ready, busy, done, no_move, best_score, best_from, best_dir, arb_posout});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 checks++;
    if (busy !== 1'b0 || sq_ready !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy=%b sq_ready=%b want 0 0", busy, sq_ready);
    end
  endtask

  task automatic test_single_ur();
    clear_squares(); nsq = 1; sq_pos[0] = 27; sq_sc[0][5] = 12;
    do_pass(0);
    checks++; if (lat_bad !== 0 || timeouts !== 0 || obs_done !== 1) begin
      errors++; $display("FAIL ur_latency: bad=%0d to=%0d done=%b want 0 0 1", lat_bad, timeouts, obs_done); end
    checks++; if (obs_score !== 12 || obs_from !== 27 || obs_dir !== 5) begin
      errors++; $display("FAIL ur_best: got %0d/%0d/%0d want 12/27/5", obs_score, obs_from, obs_dir); end
    checks++; if (obs_tgt !== 36 || obs_nomove !== 0) begin
      errors++; $display("FAIL ur_target: got %0d nm=%0d want 36 nm=0", obs_tgt, obs_nomove); end
    checks++; if (obs_done_next !== 0 || obs_busy_next !== 0 || best_score !== 12) begin
      errors++; $display("FAIL ur_after_done: done=%b busy=%b score=%0d want 0 0 12", obs_done_next, obs_busy_next, best_score); end
  endtask

  task automatic test_tie_within();
    clear_squares(); nsq = 1; sq_pos[0] = 20; sq_sc[0][3] = 7; sq_sc[0][9] = 7;
    do_pass(0);
    checks++; if (obs_dir !== 3 || obs_tgt !== 21 || obs_score !== 7 || lat_bad !== 0) begin
      errors++; $display("FAIL tie_within: dir=%0d tgt=%0d score=%0d want 3 21 7", obs_dir, obs_tgt, obs_score); end
  endtask

  task automatic test_edge_mask();
    clear_squares(); nsq = 1; sq_pos[0] = 7; sq_sc[0][3] = 31; sq_sc[0][0] = 2;
    do_pass(0);
    checks++; if (obs_dir !== 0 || obs_score !== 2 || obs_tgt !== 15) begin
      errors++; $display("FAIL edge_mask: dir=%0d score=%0d tgt=%0d want 0 2 15", obs_dir, obs_score, obs_tgt); end
  endtask

  task automatic test_multi_tie();
    clear_squares(); nsq = 3;
    sq_pos[0] = 10; sq_sc[0][0] = 9;
    sq_pos[1] = 20; sq_sc[1][3] = 9;
    sq_pos[2] = 30; sq_sc[2][1] = 11;
    do_pass(0);
    checks++; if (obs_from !== 30 || obs_score !== 11 || obs_tgt !== 22 || lat_bad !== 0 || timeouts !== 0) begin
      errors++; $display("FAIL multi_max_last: from=%0d score=%0d tgt=%0d lat_bad=%0d want 30 11 22 0", obs_from, obs_score, obs_tgt, lat_bad); end
    sq_sc[2][1] = 9;
    do_pass(0);
    checks++; if (obs_from !== 10 || obs_score !== 9 || obs_dir !== 0 || obs_tgt !== 18) begin
      errors++; $display("FAIL multi_tie_first: from=%0d score=%0d dir=%0d tgt=%0d want 10 9 0 18", obs_from, obs_score, obs_dir, obs_tgt); end
  endtask

  task automatic test_all_zero();
    clear_squares(); nsq = 2; sq_pos[0] = 0; sq_pos[1] = 63;
    do_pass(1);
    checks++; if (obs_nomove !== 1 || obs_score !== 0 || obs_tgt !== 0) begin
      errors++; $display("FAIL all_zero: nm=%0d score=%0d tgt=%0d want 1 0 0", obs_nomove, obs_score, obs_tgt); end
    checks++; if (lat_bad !== 0 || timeouts !== 0 || obs_done !== 1 || obs_done_next !== 0 || extra_done !== 0) begin
      errors++; $display("FAIL zero_single_done: lat_bad=%0d to=%0d done=%b next=%b extra=%0d want 0 0 1 0 0",
        lat_bad, timeouts, obs_done, obs_done_next, extra_done); end
    checks++; if (no_move !== 1'b1) begin
      errors++; $display("FAIL no_move_held: got %b want 1", no_move); end
  endtask

  task automatic test_reset_midscan();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    pos_in = 6'd36; sq_last = 1'b1; sq_valid = 1'b1;
    for (int k = 0; k < NL; k++) cand_scores[k*SW +: SW] = 5'd5;
    @(posedge clk); #1 sq_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 checks++;
    if (busy !== 1'b1 || best_score !== 5'd5) begin
      errors++; $display("FAIL midscan_state: busy=%b score=%0d want 1 5", busy, best_score); end
    rst_n = 1'b0;
    #1 checks++;
    if ({sq_ready, busy, done, no_move, best_score, best_from, best_dir, arb_posout} !== '0) begin
      errors++; $display("FAIL midscan_reset: got %h want 0",
        {sq_ready, busy, done, no_move, best_score, best_from, best_dir, arb_posout}); end
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sq_ready !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: busy=%b done=%b rdy=%b want 0 0 0", busy, done, sq_ready); end
    clear_squares(); nsq = 1; sq_pos[0] = 0; sq_sc[0][9] = 20; sq_sc[0][1] = 30;
    do_pass(0); model_pass();
    checks++; if (obs_score !== exp_score || obs_from !== exp_from || obs_dir !== exp_dir || obs_tgt !== exp_tgt || lat_bad !== 0) begin
      errors++; $display("FAIL post_reset_pass: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
        obs_score, obs_from, obs_dir, obs_tgt, exp_score, exp_from, exp_dir, exp_tgt); end
  endtask

  task automatic test_random();
    for (int p = 0; p < 25; p++) begin
      clear_squares();
      nsq = $urandom_range(1, 4);
      for (int i = 0; i < nsq; i++) begin
        sq_pos[i] = $urandom_range(0, 63);
        for (int k = 0; k < NL; k++)
          sq_sc[i][k] = ($urandom_range(0, 2) == 0) ? 0 :
                        (($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : $urandom_range(1, 31));
      end
      do_pass(0); model_pass();
      checks++; if (obs_score !== exp_score || obs_from !== exp_from || obs_dir !== exp_dir) begin
        errors++; $display("FAIL rand_best[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d",
          p, obs_score, obs_from, obs_dir, exp_score, exp_from, exp_dir); end
      checks++; if (obs_tgt !== exp_tgt || obs_nomove !== (exp_score == 0) || lat_bad !== 0 || timeouts !== 0) begin
        errors++; $display("FAIL rand_tgt[%0d]: tgt=%0d nm=%0d lat_bad=%0d to=%0d want %0d %0d 0 0",
          p, obs_tgt, obs_nomove, lat_bad, timeouts, exp_tgt, (exp_score == 0)); end
    end
  endtask

  initial begin
    test_reset();
    test_single_ur();
    test_tie_within();
    test_edge_mask();
    test_multi_tie();
    test_all_zero();
    test_reset_midscan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
